// File: rtl/seq_pkg.sv
// Shared types and constants for the serial frame transmitter.
// Frame = sync pattern, payload (both MSB first), optional even-parity bit, one idle gap.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    PARITY,
    GAP
  } state_e;

  localparam logic [3:0] SYNC_PAT_DEFAULT = 4'b1101;

  // Number of contiguous valid bit-cycles in one frame (gap cycle excluded).
  function automatic int frame_len(input int sync_w, input int data_w, input int parity_en);
    return sync_w + data_w + ((parity_en != 0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/seq_piso.sv
// Parallel-in/serial-out shift register, MSB first.
// o_nxt exposes the bit that becomes the MSB after the next shift.
module seq_piso #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_data,
  output logic         o_msb,
  output logic         o_nxt
);

  logic [W-1:0] r_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_data;
    end else if (i_shift) begin
      r_sr <= r_sr << 1;
    end
  end

  assign o_msb = r_sr[W-1];

  generate
    if (W > 1) begin : g_nxt
      assign o_nxt = r_sr[W-2];
    end else begin : g_nxt_single
      assign o_nxt = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: one bit per clock, sync pattern, payload, optional parity, gap.
// Handshake: a word is taken on a rising edge where in_valid && in_ready; in_ready is high only in IDLE.
module seq_frame_tx
  import seq_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                SYNC_W    = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT  = SYNC_W'(SYNC_PAT_DEFAULT),
  parameter int                PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_bit,
  output logic              out_valid,
  output logic              busy,
  output logic              frame_done,
  output state_e            dbg_state
);

  localparam int MAX_W = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_par;
  logic             r_out_bit;
  logic             r_out_valid;
  logic             r_frame_done;

  logic             w_accept;
  logic             w_shift;
  logic             w_msb;
  logic             w_nxt;
  logic [CNT_W-1:0] w_cnt_dec;
  logic             w_sync_nxt;

  assign w_accept  = in_valid && (r_state == IDLE);
  assign w_shift   = (r_state == DATA) && (r_cnt != '0);
  assign w_cnt_dec = r_cnt - CNT_W'(1);

  // Sync bit that follows the one currently on the line.
  always_comb begin
    w_sync_nxt = 1'b0;
    for (int i = 0; i < SYNC_W; i++) begin
      if (w_cnt_dec == CNT_W'(i)) w_sync_nxt = SYNC_PAT[i];
    end
  end

  seq_piso #(.W(DATA_W)) u_piso (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_data  (in_data),
    .o_msb   (w_msb),
    .o_nxt   (w_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_par        <= 1'b0;
      r_out_bit    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_out_bit   <= 1'b0;
          r_out_valid <= 1'b0;
          if (in_valid) begin
            r_par       <= ^in_data;
            r_out_bit   <= SYNC_PAT[SYNC_W-1];
            r_out_valid <= 1'b1;
            r_cnt       <= CNT_W'(SYNC_W - 1);
            r_state     <= SYNC;
          end
        end
        SYNC: begin
          if (r_cnt == '0) begin
            r_out_bit <= w_msb;
            r_cnt     <= CNT_W'(DATA_W - 1);
            r_state   <= DATA;
          end else begin
            r_out_bit <= w_sync_nxt;
            r_cnt     <= w_cnt_dec;
          end
        end
        DATA: begin
          if (r_cnt != '0) begin
            r_out_bit <= w_nxt;
            r_cnt     <= w_cnt_dec;
          end else if (PARITY_EN != 0) begin
            r_out_bit <= r_par;
            r_state   <= PARITY;
          end else begin
            r_out_bit    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b1;
            r_state      <= GAP;
          end
        end
        PARITY: begin
          r_out_bit    <= 1'b0;
          r_out_valid  <= 1'b0;
          r_frame_done <= 1'b1;
          r_state      <= GAP;
        end
        GAP: begin
          r_out_bit   <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_out_bit   <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign out_bit    = r_out_bit;
  assign out_valid  = r_out_valid;
  assign frame_done = r_frame_done;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench for seq_frame_tx: three configurations (default, no parity, 1-bit sync/data)
// checked bit by bit against a queue of expected frame bits built from the frame rules.
module tb_seq_frame_tx;
  import seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] in_valid;
  logic [7:0] in_data [3];
  wire  [2:0] in_ready;
  wire  [2:0] out_bit;
  wire  [2:0] out_valid;
  wire  [2:0] busy;
  wire  [2:0] frame_done;
  state_e     dbg0, dbg1, dbg2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_q[$];
  logic [0:0] exp_q[$];

  int         sw  [3] = '{4, 4, 1};
  int         dw  [3] = '{8, 8, 1};
  int         pe  [3] = '{1, 0, 1};
  logic [7:0] pat [3] = '{8'h0D, 8'h0D, 8'h01};

  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  seq_frame_tx u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_bit(out_bit[0]), .out_valid(out_valid[0]),
    .busy(busy[0]), .frame_done(frame_done[0]), .dbg_state(dbg0)
  );

  seq_frame_tx #(.PARITY_EN(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_bit(out_bit[1]), .out_valid(out_valid[1]),
    .busy(busy[1]), .frame_done(frame_done[1]), .dbg_state(dbg1)
  );

  seq_frame_tx #(.DATA_W(1), .SYNC_W(1), .SYNC_PAT(1'b1), .PARITY_EN(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2][0:0]), .out_bit(out_bit[2]), .out_valid(out_valid[2]),
    .busy(busy[2]), .frame_done(frame_done[2]), .dbg_state(dbg2)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && in_valid[0] && in_ready[0]) acc_q.push_back(cyc);
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_model(input int k, input logic [7:0] d);
    logic p;
    p = 1'b0;
    exp_q.delete();
    for (int i = sw[k] - 1; i >= 0; i--) exp_q.push_back(pat[k][i]);
    for (int i = dw[k] - 1; i >= 0; i--) begin
      exp_q.push_back(d[i]);
      p = p ^ d[i];
    end
    if (pe[k] != 0) exp_q.push_back(p);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input int k, input logic [7:0] d, input bit hold);
    int n;
    n = 0;
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    while (!in_ready[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("k%0d accept_wait_ok", k), 32'(n < 40), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) in_valid[k] = 1'b0;
  endtask

  task automatic expect_frame(input int k, input logic [7:0] d, input int poke);
    int i;
    logic [0:0] b;
    i = 0;
    load_model(k, d);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      b = exp_q.pop_front();
      chk($sformatf("k%0d bit%0d valid", k, i), out_valid[k], 1);
      chk($sformatf("k%0d bit%0d value", k, i), out_bit[k], b);
      chk($sformatf("k%0d bit%0d busy", k, i), busy[k], 1);
      chk($sformatf("k%0d bit%0d done", k, i), frame_done[k], 0);
      chk($sformatf("k%0d bit%0d ready", k, i), in_ready[k], 0);
      if (i == poke) begin
        in_valid[k] = 1'b1;
        in_data[k]  = 8'h3C;
      end
      if (i == poke + 2) in_valid[k] = 1'b0;
      i++;
    end
    @(negedge clk);
    chk($sformatf("k%0d gap valid", k), out_valid[k], 0);
    chk($sformatf("k%0d gap bit", k), out_bit[k], 0);
    chk($sformatf("k%0d gap done", k), frame_done[k], 1);
    chk($sformatf("k%0d gap busy", k), busy[k], 1);
    chk($sformatf("k%0d gap ready", k), in_ready[k], 0);
    @(negedge clk);
    chk($sformatf("k%0d post ready", k), in_ready[k], 1);
    chk($sformatf("k%0d post busy", k), busy[k], 0);
    chk($sformatf("k%0d post done", k), frame_done[k], 0);
    chk($sformatf("k%0d post valid", k), out_valid[k], 0);
  endtask

  task automatic check_idle_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s k%0d valid", tag, k), out_valid[k], 0);
      chk($sformatf("%s k%0d bit", tag, k), out_bit[k], 0);
      chk($sformatf("%s k%0d busy", tag, k), busy[k], 0);
      chk($sformatf("%s k%0d done", tag, k), frame_done[k], 0);
      chk($sformatf("%s k%0d ready", tag, k), in_ready[k], 1);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n_acc;
    int cnt;
    logic [7:0] d;

    rst_n    = 1'b1;
    in_valid = '0;
    for (int k = 0; k < 3; k++) in_data[k] = '0;
    #2 rst_n = 1'b0;
    #1 check_idle_all("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_all("after_reset");

    // Test 1: default frame of 8'hA5
    send(0, 8'hA5, 0);
    expect_frame(0, 8'hA5, -1);

    // Test 2: in_valid held, back-to-back 8'h01 then 8'hFF
    send(0, 8'h01, 1);
    in_data[0] = 8'hFF;
    expect_frame(0, 8'h01, -1);
    send(0, 8'hFF, 0);
    expect_frame(0, 8'hFF, -1);
    chk("accept_spacing", 32'(acc_q[acc_q.size()-1] - acc_q[acc_q.size()-2]), 32'd15);

    // Test 3: pulse mid-frame is ignored
    send(0, 8'hA5, 0);
    n_acc = acc_q.size();
    expect_frame(0, 8'hA5, 3);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid[0]) cnt++;
    end
    chk("no_second_frame_bits", 32'(cnt), 32'd0);
    chk("no_second_accept", 32'(acc_q.size()), 32'(n_acc));

    // Test 4: reset during the 3rd payload bit
    send(0, 8'hA5, 0);
    repeat (6) @(negedge clk);
    @(negedge clk);
    chk("abort pre bit", out_bit[0], 1);
    chk("abort pre valid", out_valid[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort valid", out_valid[0], 0);
    chk("abort busy", busy[0], 0);
    chk("abort ready", in_ready[0], 1);
    chk("abort bit", out_bit[0], 0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (frame_done[0] || out_valid[0]) cnt++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (frame_done[0] || out_valid[0]) cnt++;
    end
    chk("abort no_completion", 32'(cnt), 32'd0);
    send(0, 8'hA5, 0);
    expect_frame(0, 8'hA5, -1);

    // Test 5: no parity, 8'h81
    send(1, 8'h81, 0);
    expect_frame(1, 8'h81, -1);

    // Test 6: 1-bit sync, 1-bit data
    send(2, 8'h01, 0);
    expect_frame(2, 8'h01, -1);

    // Randomized frames on every configuration
    for (int r = 0; r < 6; r++) begin
      d = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(0, d, 0);
      expect_frame(0, d, -1);
    end
    for (int r = 0; r < 4; r++) begin
      d = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(1, d, 0);
      expect_frame(1, d, -1);
    end
    for (int r = 0; r < 4; r++) begin
      d = 8'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(2, d, 0);
      expect_frame(2, d, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
